// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect input and decode-side buffer head.
// Optional misalign_err member exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
    output misalign_err,
`endif
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, opcode, funct3, funct7,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_target, instr_ready
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
    input  misalign_err,
`endif
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, opcode, funct3, funct7,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_target, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a small circular instruction buffer toward decode.
// Define FETCH_MISALIGN_CHECK_EN to add the sticky misaligned-redirect flag (bus.misalign_err).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DISCARD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       r_issue_pc;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [31:0]       r_buf_instr [BUF_DEPTH];
  logic [31:0]       r_buf_pc    [BUF_DEPTH];

  logic        w_req_valid;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_has_data;
  logic        w_not_full;
  logic [31:0] w_target;
  logic [31:0] w_head_instr;
  logic [31:0] w_head_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_has_data = (r_count != '0);
  assign w_not_full = (r_count < CNT_W'(BUF_DEPTH));
  assign w_target   = {bus.redirect_target[31:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and request valid; a response always closes the outstanding request
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_valid = rst_n && w_not_full && !bus.redirect;
        if (w_req_valid && bus.imem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) w_state_nxt = ST_IDLE;
        else if (bus.redirect)  w_state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (bus.imem_rsp_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_issue = w_req_valid && bus.imem_req_ready;
  assign w_push  = (r_state == ST_WAIT) && bus.imem_rsp_valid && !bus.redirect;
  assign w_pop   = w_has_data && bus.instr_ready && !bus.redirect;

  // PC, occupancy and pointers; redirect flushes and wins over everything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= {RESET_PC[31:2], 2'b00};
      r_issue_pc <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_issue) r_issue_pc <= r_pc;
      if (bus.redirect) begin
        r_pc     <= w_target;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_issue) r_pc     <= r_pc + 32'd4;
        if (w_push)  r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Buffer storage carries no reset; validity comes from r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= bus.imem_rsp_data;
      r_buf_pc[r_wr_ptr]    <= r_issue_pc;
    end
  end

  assign w_head_instr = w_has_data ? r_buf_instr[r_rd_ptr] : '0;
  assign w_head_pc    = w_has_data ? r_buf_pc[r_rd_ptr]    : '0;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.instr_valid    = w_has_data;
  assign bus.instr          = w_head_instr;
  assign bus.instr_pc       = w_head_pc;
  assign bus.opcode         = w_head_instr[6:0];
  assign bus.funct3         = w_head_instr[14:12];
  assign bus.funct7         = w_head_instr[31:25];

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            r_misalign_err <= 1'b0;
    else if (bus.redirect && (bus.redirect_target[1:0] != 2'b00)) r_misalign_err <= 1'b1;
  end

  assign bus.misalign_err = r_misalign_err;
`else
  logic w_unused_target_lsb;
  assign w_unused_target_lsb = ^bus.redirect_target[1:0];
`endif

endmodule
